gig_eth_tx_arb: RTL and testbench

//  Round-robin arbiter sharing one gig_eth_mac TX client port among NUM_REQ frame sources
//  (e.g. probe generator, pass-through path). Grants whole frames and muxes data/dvld/underrun
//  to the MAC. Routes mac_tx_ack back to the granted source only. Sits in the tx_clk domain

---
 rtl/gig_eth_tx_arb_pkg.sv | 32 +++
 rtl/gig_eth_rr_pick.sv | 29 ++
 rtl/gig_eth_tx_arb.sv | 206 ++++++++++++++++++++
 tb/tb_gig_eth_tx_arb.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gig_eth_tx_arb_pkg.sv
// gig_eth_tx_arb_pkg
//   Shared definitions for the TX-side arbitration blocks: arbiter FSM state
//   encoding, counter widths and saturating-increment helpers.
package gig_eth_tx_arb_pkg;

  // Arbiter FSM states (2-bit encoding shared with other TX-side blocks)
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_XFER  = 2'd2,
    ARB_GAP   = 2'd3
  } arb_state_t;

  // Start-timeout timer width (START_TIMEOUT must fit)
  localparam int TIMER_W      = 16;
  // Inter-frame gap counter width (GAP_CYCLES is 0..15)
  localparam int GAP_W        = 4;
  // Statistics counter widths
  localparam int STAT_FRAME_W = 32;
  localparam int STAT_TO_W    = 16;

  // Saturating increment for 32-bit frame counters
  function automatic logic [STAT_FRAME_W-1:0] sat_inc32(input logic [STAT_FRAME_W-1:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Saturating increment for 16-bit timeout counter
  function automatic logic [STAT_TO_W-1:0] sat_inc16(input logic [STAT_TO_W-1:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/gig_eth_rr_pick.sv
// gig_eth_rr_pick
//   Combinational round-robin picker. Returns the first requester strictly
//   after the pointer, wrapping around, so the last winner has lowest priority.
// Ports
//   req  in  NUM_REQ  request vector
//   ptr  in  IDX_W    index of the previous winner
//   idx  out IDX_W    chosen index (valid only when vld=1)
//   vld  out 1        at least one request present
module gig_eth_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               vld
);

  // Scan ptr+1 .. ptr+NUM_REQ (mod NUM_REQ); first hit wins
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (req[(int'(ptr) + k) % NUM_REQ] && !vld) ? IDX_W'((int'(ptr) + k) % NUM_REQ) : idx;
      vld = vld | req[(int'(ptr) + k) % NUM_REQ];
    end
  end

endmodule

// File: rtl/gig_eth_tx_arb.sv
// gig_eth_tx_arb
//   Round-robin arbiter sharing one gig_eth_mac TX client port among NUM_REQ
//   frame sources. Whole frames are granted; data/dvld/underrun of the granted
//   source are muxed to the MAC with no added latency and mac_tx_ack is steered
//   back to the granted source only. tx_clk domain.
// Optional feature macro: GIG_ETH_TX_ARB_STATS_EN (adds stat_frames/stat_timeouts)
// Ports
//   tx_clk, reset      clock, synchronous active-high reset
//   arb_en             0 blocks new grants (frame in progress completes)
//   src_req            per-source frame ready
//   src_data           byte lane per source, src i = [8i+7:8i]
//   src_dvld           per-source data valid
//   src_underrun       per-source underrun
//   src_grant          one-hot grant, held for the whole frame
//   src_ack            mac_tx_ack steered to the granted source
//   mac_tx_data/dvld/underrun  to MAC
//   mac_tx_ack         from MAC, first byte accepted
//   arb_timeout        1-cycle pulse when a grant is revoked for not starting
//   stat_frames        (stats) per-source frames completed cleanly, saturating
//   stat_timeouts      (stats) start timeouts, saturating
module gig_eth_tx_arb
  import gig_eth_tx_arb_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int GAP_CYCLES    = 2,
  parameter int START_TIMEOUT = 64
) (
  input  logic                   tx_clk,
  input  logic                   reset,
  input  logic                   arb_en,
  input  logic [NUM_REQ-1:0]     src_req,
  input  logic [8*NUM_REQ-1:0]   src_data,
  input  logic [NUM_REQ-1:0]     src_dvld,
  input  logic [NUM_REQ-1:0]     src_underrun,
  output logic [NUM_REQ-1:0]     src_grant,
  output logic [NUM_REQ-1:0]     src_ack,
  output logic [7:0]             mac_tx_data,
  output logic                   mac_tx_dvld,
  output logic                   mac_tx_underrun,
  input  logic                   mac_tx_ack,
  output logic                   arb_timeout
`ifdef GIG_ETH_TX_ARB_STATS_EN
  ,
  output logic [32*NUM_REQ-1:0]  stat_frames,
  output logic [STAT_TO_W-1:0]   stat_timeouts
`endif
);

  localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Last GAP count value; GAP always lasts at least one cycle
  localparam int GAP_LAST = (GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0;

  arb_state_t            state_r;
  logic [IDX_W-1:0]      g_r;
  logic [IDX_W-1:0]      ptr_r;
  logic [TIMER_W-1:0]    timer_r;
  logic [GAP_W-1:0]      gap_cnt_r;
  logic                  seen_dvld_r;

  logic [IDX_W-1:0]      pick_idx_s;
  logic                  pick_vld_s;
  logic                  g_dvld_s;
  logic                  g_under_s;
  logic [7:0]            g_data_s;
  logic                  mux_active_s;
  logic                  timeout_hit_s;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      oh[i] = (idx == IDX_W'(i));
    end
    return oh;
  endfunction

  gig_eth_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req (src_req),
    .ptr (ptr_r),
    .idx (pick_idx_s),
    .vld (pick_vld_s)
  );

  assign g_dvld_s      = src_dvld[g_r];
  assign g_under_s     = src_underrun[g_r];
  assign g_data_s      = src_data[g_r*8 +: 8];
  assign mux_active_s  = (state_r == ARB_GRANT) || (state_r == ARB_XFER);
  // Granted source never raised dvld within the start window
  assign timeout_hit_s = (state_r == ARB_GRANT) && !seen_dvld_r && !g_dvld_s &&
                         !mac_tx_ack && (timer_r == TIMER_W'(START_TIMEOUT - 1));

  // MAC-side mux and ack steering, combinational from registered grant index
  always_comb begin
    mac_tx_dvld     = 1'b0;
    mac_tx_underrun = 1'b0;
    mac_tx_data     = 8'h00;
    src_ack         = '0;
    if (mux_active_s) begin
      mac_tx_dvld     = g_dvld_s;
      mac_tx_underrun = g_under_s;
      mac_tx_data     = g_dvld_s ? g_data_s : 8'h00;
    end else begin
      mac_tx_dvld     = 1'b0;
      mac_tx_underrun = 1'b0;
      mac_tx_data     = 8'h00;
    end
    if (state_r == ARB_GRANT) begin
      src_ack[g_r] = mac_tx_ack;
    end else begin
      src_ack = '0;
    end
  end

  // Arbiter FSM with grant, pointer, start timer and gap counter
  always_ff @(posedge tx_clk) begin
    if (reset) begin
      state_r     <= ARB_IDLE;
      g_r         <= '0;
      ptr_r       <= IDX_W'(NUM_REQ - 1);
      timer_r     <= '0;
      gap_cnt_r   <= '0;
      seen_dvld_r <= 1'b0;
      src_grant   <= '0;
      arb_timeout <= 1'b0;
    end else begin
      arb_timeout <= 1'b0;
      case (state_r)
        ARB_IDLE: begin
          if (arb_en && pick_vld_s) begin
            g_r         <= pick_idx_s;
            ptr_r       <= pick_idx_s;
            src_grant   <= idx_to_onehot(pick_idx_s);
            timer_r     <= '0;
            seen_dvld_r <= 1'b0;
            state_r     <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          timer_r <= timer_r + 1'b1;
          if (g_dvld_s) begin
            seen_dvld_r <= 1'b1;
          end
          if (mac_tx_ack) begin
            state_r <= ARB_XFER;
          end else if (seen_dvld_r && !g_dvld_s) begin
            // dvld dropped before the MAC accepted the first byte: abort
            state_r   <= ARB_GAP;
            src_grant <= '0;
            gap_cnt_r <= '0;
          end else if (timeout_hit_s) begin
            arb_timeout <= 1'b1;
            state_r     <= ARB_GAP;
            src_grant   <= '0;
            gap_cnt_r   <= '0;
          end
        end
        ARB_XFER: begin
          if (!g_dvld_s || g_under_s) begin
            state_r   <= ARB_GAP;
            src_grant <= '0;
            gap_cnt_r <= '0;
          end
        end
        ARB_GAP: begin
          if (gap_cnt_r == GAP_W'(GAP_LAST)) begin
            state_r <= ARB_IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r + 1'b1;
          end
        end
        default: begin
          state_r   <= ARB_IDLE;
          src_grant <= '0;
        end
      endcase
    end
  end

`ifdef GIG_ETH_TX_ARB_STATS_EN
  logic frame_done_s;

  // Clean end of frame: dvld dropped in XFER without underrun
  assign frame_done_s = (state_r == ARB_XFER) && !g_dvld_s && !g_under_s;

  // Saturating per-source frame counters and timeout counter
  always_ff @(posedge tx_clk) begin
    if (reset) begin
      stat_frames   <= '0;
      stat_timeouts <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (frame_done_s && (g_r == IDX_W'(i))) begin
          stat_frames[32*i +: 32] <= sat_inc32(stat_frames[32*i +: 32]);
        end
      end
      if (timeout_hit_s) begin
        stat_timeouts <= sat_inc16(stat_timeouts);
      end
    end
  end
`endif

endmodule

// File: tb/tb_gig_eth_tx_arb.sv
// tb_gig_eth_tx_arb
//   Directed bench for gig_eth_tx_arb (NUM_REQ=2, GAP_CYCLES=2, START_TIMEOUT=64):
//   a per-cycle vector table for grant/mux/ack behaviour, then hand-written
//   sequences for multi-cycle cases (alternation, gap, timeout, underrun,
//   arb_en, delayed ack, reset mid-frame).
module tb_gig_eth_tx_arb;

  logic         tx_clk = 1'b0;
  logic         reset;
  logic         arb_en;
  logic [1:0]   src_req;
  logic [15:0]  src_data;
  logic [1:0]   src_dvld;
  logic [1:0]   src_underrun;
  logic [1:0]   src_grant;
  logic [1:0]   src_ack;
  logic [7:0]   mac_tx_data;
  logic         mac_tx_dvld;
  logic         mac_tx_underrun;
  logic         mac_tx_ack;
  logic         arb_timeout;
`ifdef GIG_ETH_TX_ARB_STATS_EN
  logic [63:0]  stat_frames;
  logic [15:0]  stat_timeouts;
`endif

  int checks   = 0;
  int failures = 0;

  gig_eth_tx_arb #(
    .NUM_REQ       (2),
    .GAP_CYCLES    (2),
    .START_TIMEOUT (64)
  ) dut (
    .tx_clk          (tx_clk),
    .reset           (reset),
    .arb_en          (arb_en),
    .src_req         (src_req),
    .src_data        (src_data),
    .src_dvld        (src_dvld),
    .src_underrun    (src_underrun),
    .src_grant       (src_grant),
    .src_ack         (src_ack),
    .mac_tx_data     (mac_tx_data),
    .mac_tx_dvld     (mac_tx_dvld),
    .mac_tx_underrun (mac_tx_underrun),
    .mac_tx_ack      (mac_tx_ack),
    .arb_timeout     (arb_timeout)
`ifdef GIG_ETH_TX_ARB_STATS_EN
    ,
    .stat_frames     (stat_frames),
    .stat_timeouts   (stat_timeouts)
`endif
  );

  always #5 tx_clk = ~tx_clk;

  typedef struct {
    logic       en;
    logic [1:0] req;
    logic [1:0] dvld;
    logic [1:0] under;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       ack;
    logic [1:0] e_grant;
    logic       e_dvld;
    logic [7:0] e_data;
    logic       e_under;
    logic [1:0] e_ack;
    logic       e_to;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int s, input int b);
    return 8'((s << 6) + b * 3 + 1);
  endfunction

  task automatic do_reset();
    reset        = 1'b1;
    arb_en       = 1'b0;
    src_req      = 2'b00;
    src_data     = 16'h0000;
    src_dvld     = 2'b00;
    src_underrun = 2'b00;
    mac_tx_ack   = 1'b0;
    repeat (3) @(negedge tx_clk);
    reset = 1'b0;
  endtask

  // Waits for a grant (bounded) and checks who got it and how many grant-free cycles passed
  task automatic wait_grant(input logic [1:0] exp_g, input int exp_idle);
    int idle;
    idle = 0;
    @(negedge tx_clk);
    #1;
    while (src_grant == 2'b00 && idle < 200) begin
      idle++;
      @(negedge tx_clk);
      #1;
    end
    check("grant", 32'(src_grant), 32'(exp_g));
    if (exp_idle >= 0) begin
      check("gap_cycles", 32'(idle), 32'(exp_idle));
    end
  endtask

  // Source + MAC model for one frame; called in the first cycle of the grant
  task automatic frame(input int s, input int len, input int ack_dly, input int und_at);
    logic [1:0] oh;
    oh = 2'(2'b01 << s);
    src_dvld[s] = 1'b1;
    src_data[8*s +: 8] = pat(s, 0);
    for (int d = 0; d <= ack_dly; d++) begin
      mac_tx_ack = (d == ack_dly);
      #1;
      check("hold_byte", 32'({mac_tx_dvld, mac_tx_data}), 32'({1'b1, pat(s, 0)}));
      check("src_ack", 32'(src_ack), (d == ack_dly) ? 32'(oh) : 32'd0);
      @(negedge tx_clk);
    end
    mac_tx_ack = 1'b0;
    for (int b = 1; b < len; b++) begin
      src_data[8*s +: 8] = pat(s, b);
      src_underrun[s] = (b == und_at);
      #1;
      check("byte", 32'(mac_tx_data), 32'(pat(s, b)));
      check("underrun", 32'(mac_tx_underrun), (b == und_at) ? 32'd1 : 32'd0);
      @(negedge tx_clk);
      if (b == und_at) break;
    end
    src_dvld[s] = 1'b0;
    src_underrun[s] = 1'b0;
    src_data[8*s +: 8] = 8'h00;
    #1;
    check("end_dvld", 32'(mac_tx_dvld), 32'd0);
  endtask

  initial begin
    int  k;
    logic saw_dvld;

    //                 en  req    dvld   under  d0     d1     ack   grant  dv  data   un  ack    to
    vecs[0]  = '{1'b1, 2'b11, 2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0};
    vecs[1]  = '{1'b1, 2'b11, 2'b10, 2'b00, 8'hA5, 8'hB5, 1'b0, 2'b01, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0};
    vecs[2]  = '{1'b1, 2'b11, 2'b01, 2'b00, 8'hA0, 8'hB5, 1'b0, 2'b01, 1'b1, 8'hA0, 1'b0, 2'b00, 1'b0};
    vecs[3]  = '{1'b1, 2'b11, 2'b11, 2'b00, 8'hA0, 8'hB7, 1'b0, 2'b01, 1'b1, 8'hA0, 1'b0, 2'b00, 1'b0};
    vecs[4]  = '{1'b1, 2'b11, 2'b01, 2'b00, 8'hA0, 8'hB7, 1'b1, 2'b01, 1'b1, 8'hA0, 1'b0, 2'b01, 1'b0};
    vecs[5]  = '{1'b1, 2'b11, 2'b01, 2'b00, 8'hA1, 8'hB7, 1'b1, 2'b01, 1'b1, 8'hA1, 1'b0, 2'b00, 1'b0};
    vecs[6]  = '{1'b1, 2'b11, 2'b01, 2'b10, 8'hA2, 8'hB7, 1'b0, 2'b01, 1'b1, 8'hA2, 1'b0, 2'b00, 1'b0};
    vecs[7]  = '{1'b1, 2'b11, 2'b01, 2'b01, 8'hA3, 8'hB7, 1'b0, 2'b01, 1'b1, 8'hA3, 1'b1, 2'b00, 1'b0};
    vecs[8]  = '{1'b1, 2'b11, 2'b01, 2'b00, 8'hA4, 8'hB7, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0};
    vecs[9]  = '{1'b1, 2'b11, 2'b00, 2'b00, 8'hA4, 8'hB7, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0};
    vecs[10] = '{1'b1, 2'b11, 2'b00, 2'b00, 8'hA4, 8'hB7, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0};
    vecs[11] = '{1'b1, 2'b11, 2'b01, 2'b00, 8'hAA, 8'hB7, 1'b0, 2'b10, 1'b0, 8'h00, 1'b0, 2'b00, 1'b0};

    // Per-cycle vector table starting right after reset
    do_reset();
    for (int i = 0; i < 12; i++) begin
      arb_en       = vecs[i].en;
      src_req      = vecs[i].req;
      src_dvld     = vecs[i].dvld;
      src_underrun = vecs[i].under;
      src_data     = {vecs[i].d1, vecs[i].d0};
      mac_tx_ack   = vecs[i].ack;
      #1;
      check($sformatf("vec%0d", i),
            32'({src_grant, mac_tx_dvld, mac_tx_data, mac_tx_underrun, src_ack, arb_timeout}),
            32'({vecs[i].e_grant, vecs[i].e_dvld, vecs[i].e_data, vecs[i].e_under, vecs[i].e_ack, vecs[i].e_to}));
      @(negedge tx_clk);
    end

    // Both sources request: grants alternate, gap of GAP_CYCLES plus arbitration cycle
    do_reset();
    arb_en  = 1'b1;
    src_req = 2'b11;
    wait_grant(2'b01, -1);
    frame(0, 64, 2, -1);
    wait_grant(2'b10, 3);
    frame(1, 64, 1, -1);
    wait_grant(2'b01, 3);
    frame(0, 64, 3, -1);
    wait_grant(2'b10, 3);
    frame(1, 64, 0, -1);
    src_req = 2'b00;
    repeat (2) @(negedge tx_clk);
`ifdef GIG_ETH_TX_ARB_STATS_EN
    check("stat_frames_alt", stat_frames[31:0], 32'd2);
    check("stat_frames_alt1", stat_frames[63:32], 32'd2);
`endif

    // Single requester is regranted after each gap
    do_reset();
    arb_en  = 1'b1;
    src_req = 2'b10;
    wait_grant(2'b10, -1);
    frame(1, 16, 1, -1);
    wait_grant(2'b10, 3);
    frame(1, 16, 1, -1);
    wait_grant(2'b10, 3);
    frame(1, 8, 0, -1);

    // Granted source never starts: timeout pulse 64 cycles after grant, then src1
    do_reset();
    arb_en   = 1'b1;
    src_req  = 2'b11;
    wait_grant(2'b01, -1);
    src_dvld = 2'b10;
    saw_dvld = 1'b0;
    k = 0;
    while (!arb_timeout && k < 100) begin
      saw_dvld = saw_dvld | mac_tx_dvld;
      @(negedge tx_clk);
      #1;
      k++;
    end
    check("timeout_delay", 32'(k), 32'd64);
    check("timeout_no_dvld", 32'(saw_dvld | mac_tx_dvld), 32'd0);
    check("timeout_gap_grant", 32'(src_grant), 32'd0);
    @(negedge tx_clk);
    #1;
    check("timeout_pulse_len", 32'(arb_timeout), 32'd0);
`ifdef GIG_ETH_TX_ARB_STATS_EN
    check("stat_timeouts", 32'(stat_timeouts), 32'd1);
`endif
    src_dvld = 2'b00;
    wait_grant(2'b10, 1);

    // Underrun at byte 20 forwarded the same cycle, grant drops next cycle
    do_reset();
    arb_en  = 1'b1;
    src_req = 2'b01;
    wait_grant(2'b01, -1);
    frame(0, 64, 1, 20);
    check("underrun_gap_grant", 32'(src_grant), 32'd0);
    src_req = 2'b00;
    repeat (3) @(negedge tx_clk);
`ifdef GIG_ETH_TX_ARB_STATS_EN
    check("stat_frames_underrun", stat_frames[31:0], 32'd0);
`endif

    // arb_en low mid-frame: frame completes, no grant while low, grant 1 cycle after high
    do_reset();
    arb_en  = 1'b1;
    src_req = 2'b11;
    wait_grant(2'b01, -1);
    arb_en  = 1'b0;
    frame(0, 20, 1, -1);
    saw_dvld = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge tx_clk);
      #1;
      saw_dvld = saw_dvld | (src_grant != 2'b00);
    end
    check("en_low_no_grant", 32'(saw_dvld), 32'd0);
    @(negedge tx_clk);
    arb_en = 1'b1;
    #1;
    check("en_rise_same_cycle", 32'(src_grant), 32'd0);
    @(negedge tx_clk);
    #1;
    check("en_rise_next_cycle", 32'(src_grant), 32'b10);

    // mac_tx_ack delayed 10 cycles: first byte held, ack only to src1
    do_reset();
    arb_en  = 1'b1;
    src_req = 2'b10;
    wait_grant(2'b10, -1);
    frame(1, 8, 10, -1);

    // Reset mid-frame truncates: mac_tx_dvld low in the cycle after reset is sampled
    do_reset();
    arb_en  = 1'b1;
    src_req = 2'b01;
    wait_grant(2'b01, -1);
    src_dvld   = 2'b01;
    src_data   = 16'h0033;
    mac_tx_ack = 1'b1;
    @(negedge tx_clk);
    mac_tx_ack = 1'b0;
    @(negedge tx_clk);
    reset = 1'b1;
    #1;
    check("pre_reset_dvld", 32'(mac_tx_dvld), 32'd1);
    @(negedge tx_clk);
    #1;
    check("post_reset_out", 32'({src_grant, mac_tx_dvld, mac_tx_data}), 32'd0);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
